// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: initiator for a 2-read/1-write register file.
// Accepts one register-to-register command, reads both operands, computes
// the result and writes it back, completing one command every 4 cycles.
module reg_op_sequencer #(
    parameter int Addr_width = 4,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [Addr_width-1:0] cmd_dst,
    input  logic [Addr_width-1:0] cmd_src1,
    input  logic [Addr_width-1:0] cmd_src2,
    output logic [Addr_width-1:0] rf_addr_r_1,
    output logic [Addr_width-1:0] rf_addr_r_2,
    input  logic [data_width-1:0] rf_data_r_1,
    input  logic [data_width-1:0] rf_data_r_2,
    output logic                  rf_we,
    output logic [Addr_width-1:0] rf_addr_w,
    output logic [data_width-1:0] rf_data_w,
    output logic                  done,
    output logic                  flag_c,
    output logic                  flag_z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic                  cmd_ready_r;
    logic                  accept_s;
    logic [2:0]            op_r;
    logic [Addr_width-1:0] dst_r;
    logic [Addr_width-1:0] src1_r;
    logic [Addr_width-1:0] src2_r;
    logic [data_width-1:0] a_r;
    logic [data_width-1:0] b_r;
    logic [data_width-1:0] res_r;
    logic                  c_r;
    logic [data_width:0]   alu_s;
    logic                  rf_we_r;
    logic                  done_r;
    logic [Addr_width-1:0] rf_addr_w_r;
    logic                  flag_c_r;
    logic                  flag_z_r;

    // Result with carry in the top bit; the carry meaning depends on the op.
    function automatic logic [data_width:0] alu_calc(
        input logic [2:0]            op,
        input logic [data_width-1:0] a,
        input logic [data_width-1:0] b
    );
        logic [data_width:0] res;
        res = '0;
        case (op)
            3'b000:  res = {1'b0, a} + {1'b0, b};
            3'b001:  res = {1'b0, a} - {1'b0, b};   // top bit is the borrow
            3'b010:  res = {1'b0, a & b};
            3'b011:  res = {1'b0, a | b};
            3'b100:  res = {1'b0, a ^ b};
            3'b101:  res = {a, 1'b0};                // shifted-out MSB lands in carry
            3'b110:  res = {a[0], 1'b0, a[data_width-1:1]};
            3'b111:  res = {1'b0, a};
            default: res = '0;
        endcase
        return res;
    endfunction

    // cmd_ready is registered so it stays low throughout reset.
    assign accept_s    = cmd_valid & cmd_ready_r;
    assign alu_s       = alu_calc(op_r, a_r, b_r);
    assign cmd_ready   = cmd_ready_r;
    assign rf_addr_r_1 = src1_r;
    assign rf_addr_r_2 = src2_r;
    assign rf_we       = rf_we_r;
    assign rf_addr_w   = rf_addr_w_r;
    assign rf_data_w   = res_r;
    assign done        = done_r;
    assign flag_c      = flag_c_r;
    assign flag_z      = flag_z_r;

    // Next-state logic for the IDLE -> READ -> EXEC -> WRITE cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ:    next_state_s = EXEC;
            EXEC:    next_state_s = WRITE;
            WRITE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register and registered ready (high whenever the next state is IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == IDLE);
        end
    end

    // Latch the command at the handshake; these also drive the read addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= 3'd0;
            dst_r  <= '0;
            src1_r <= '0;
            src2_r <= '0;
        end else if (accept_s) begin
            op_r   <= cmd_op;
            dst_r  <= cmd_dst;
            src1_r <= cmd_src1;
            src2_r <= cmd_src2;
        end
    end

    // Capture operands only in READ, so later writes cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
        end else if (state_r == READ) begin
            a_r <= rf_data_r_1;
            b_r <= rf_data_r_2;
        end
    end

    // Register result and carry at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= '0;
            c_r   <= 1'b0;
        end else if (state_r == EXEC) begin
            res_r <= alu_s[data_width-1:0];
            c_r   <= alu_s[data_width];
        end
    end

    // Write-port strobes are high exactly during WRITE; address holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r     <= 1'b0;
            done_r      <= 1'b0;
            rf_addr_w_r <= '0;
        end else begin
            rf_we_r <= (state_r == EXEC);
            done_r  <= (state_r == EXEC);
            if (state_r == EXEC) begin
                rf_addr_w_r <= dst_r;
            end
        end
    end

    // Flags reflect the last command that completed its write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else if (state_r == WRITE) begin
            flag_c_r <= c_r;
            flag_z_r <= (res_r == '0);
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed testbench for reg_op_sequencer with a behavioural register file.
module tb_reg_op_sequencer;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_dst, cmd_src1, cmd_src2;
    logic [AW-1:0] rf_addr_r_1, rf_addr_r_2, rf_addr_w;
    logic [DW-1:0] rf_data_r_1, rf_data_r_2, rf_data_w;
    logic          rf_we, done, flag_c, flag_z;

    logic [DW-1:0] rf [0:15];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = 4'd0;
    logic [DW-1:0] pl_data = 8'd0;
    int            we_count = 0;
    int            done_count = 0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    reg_op_sequencer #(.Addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .rf_addr_r_1(rf_addr_r_1), .rf_addr_r_2(rf_addr_r_2),
        .rf_data_r_1(rf_data_r_1), .rf_data_r_2(rf_data_r_2),
        .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .done(done), .flag_c(flag_c), .flag_z(flag_z)
    );

    assign rf_data_r_1 = rf[rf_addr_r_1];
    assign rf_data_r_2 = rf[rf_addr_r_2];

    // Register file model: bench preload port has priority over the DUT write.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rf_we) rf[rf_addr_w] <= rf_data_w;
    end

    // Count write strobes and done pulses seen at clock edges.
    always @(posedge clk) begin
        if (rf_we) we_count <= we_count + 1;
        if (done) done_count <= done_count + 1;
    end

    // All tasks start and end #1 after a rising edge.
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] dst,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Returns the number of cycles after the handshake until rf_we is seen (0 if never).
    task automatic finish_cmd(output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rf_we) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_dst = 4'd0; cmd_src1 = 4'd0; cmd_src2 = 4'd0;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", cmd_ready); end
        total++; if (rf_we !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_we_done: got %0b%0b want 00", rf_we, done); end
        total++; if (flag_c !== 1'b0 || flag_z !== 1'b0) begin bad++; $display("FAIL rst_flags: got %0b%0b want 00", flag_c, flag_z); end
        total++; if (rf_addr_r_1 !== 4'd0 || rf_addr_r_2 !== 4'd0 || rf_addr_w !== 4'd0 || rf_data_w !== 8'd0) begin
            bad++; $display("FAIL rst_ports: got %h %h %h %h want 0 0 0 00", rf_addr_r_1, rf_addr_r_2, rf_addr_w, rf_data_w);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_add();
        int lat, d0, w0;
        preload(4'd1, 8'h05); preload(4'd2, 8'h03); preload(4'd4, 8'hAA);
        d0 = done_count; w0 = we_count;
        issue(3'b000, 4'd4, 4'd1, 4'd2);
        finish_cmd(lat);
        total++; if (lat != 3) begin bad++; $display("FAIL add_latency: got %0d want 3", lat); end
        total++; if (rf[4] !== 8'h08) begin bad++; $display("FAIL add_result: got %h want 08", rf[4]); end
        total++; if (flag_c !== 1'b0 || flag_z !== 1'b0) begin bad++; $display("FAIL add_flags: got c=%0b z=%0b want 0 0", flag_c, flag_z); end
        total++; if (done_count - d0 != 1) begin bad++; $display("FAIL add_done_pulses: got %0d want 1", done_count - d0); end
        total++; if (we_count - w0 != 1) begin bad++; $display("FAIL add_we_pulses: got %0d want 1", we_count - w0); end
    endtask

    task automatic test_overflow();
        int lat;
        preload(4'd1, 8'hFF); preload(4'd2, 8'h01); preload(4'd5, 8'h33);
        issue(3'b000, 4'd5, 4'd1, 4'd2);
        finish_cmd(lat);
        total++; if (rf[5] !== 8'h00) begin bad++; $display("FAIL ovf_result: got %h want 00", rf[5]); end
        total++; if (flag_c !== 1'b1 || flag_z !== 1'b1) begin bad++; $display("FAIL ovf_flags: got c=%0b z=%0b want 1 1", flag_c, flag_z); end
    endtask

    task automatic test_sub_shift();
        int lat;
        preload(4'd1, 8'h02); preload(4'd2, 8'h05);
        issue(3'b001, 4'd7, 4'd1, 4'd2);
        finish_cmd(lat);
        total++; if (rf[7] !== 8'hFD || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            bad++; $display("FAIL sub_borrow: got %h c=%0b z=%0b want fd 1 0", rf[7], flag_c, flag_z);
        end
        preload(4'd1, 8'h0F); preload(4'd2, 8'hFF);
        issue(3'b100, 4'd10, 4'd1, 4'd2);
        finish_cmd(lat);
        total++; if (rf[10] !== 8'hF0 || flag_c !== 1'b0) begin
            bad++; $display("FAIL xor: got %h c=%0b want f0 0", rf[10], flag_c);
        end
        preload(4'd1, 8'h81);
        issue(3'b101, 4'd8, 4'd1, 4'd2);
        finish_cmd(lat);
        total++; if (rf[8] !== 8'h02 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            bad++; $display("FAIL shl: got %h c=%0b z=%0b want 02 1 0", rf[8], flag_c, flag_z);
        end
        preload(4'd1, 8'h01);
        issue(3'b110, 4'd9, 4'd1, 4'd2);
        finish_cmd(lat);
        total++; if (rf[9] !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            bad++; $display("FAIL shr: got %h c=%0b z=%0b want 00 1 1", rf[9], flag_c, flag_z);
        end
    endtask

    task automatic test_mid_reset();
        int w0;
        preload(4'd12, 8'h77); preload(4'd1, 8'h01); preload(4'd2, 8'h02);
        w0 = we_count;
        issue(3'b000, 4'd12, 4'd1, 4'd2);
        @(posedge clk); #2;          // now in EXEC
        rst_n = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_async: got ready=%0b we=%0b done=%0b want 0 0 0", cmd_ready, rf_we, done);
        end
        total++; if (flag_c !== 1'b0 || flag_z !== 1'b0 || rf_addr_r_1 !== 4'd0 || rf_addr_w !== 4'd0 || rf_data_w !== 8'd0) begin
            bad++; $display("FAIL midrst_state: got c=%0b z=%0b ar1=%h aw=%h dw=%h want 0 0 0 0 00", flag_c, flag_z, rf_addr_r_1, rf_addr_w, rf_data_w);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b want 1", cmd_ready); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (we_count != w0 || rf[12] !== 8'h77) begin
            bad++; $display("FAIL midrst_nowrite: got we=%0d r12=%h want 0 77", we_count - w0, rf[12]);
        end
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, zero_cnt;
        bit will_hs;
        preload(4'd1, 8'h10); preload(4'd2, 8'h22); preload(4'd6, 8'h00);
        hs1 = -1; hs2 = -1; zero_cnt = 0;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_dst = 4'd3; cmd_src1 = 4'd1; cmd_src2 = 4'd2;
        for (int c = 0; c < 20; c++) begin
            will_hs = cmd_ready && cmd_valid;
            @(posedge clk); #1;
            if (will_hs) begin
                if (hs1 < 0) begin
                    hs1 = c;
                    cmd_op = 3'b111; cmd_dst = 4'd6; cmd_src1 = 4'd3; cmd_src2 = 4'd0;
                end else if (hs2 < 0) begin
                    hs2 = c;
                    cmd_valid = 1'b0;
                end
            end
            if (hs1 >= 0 && hs2 < 0 && !cmd_ready) zero_cnt++;
        end
        cmd_valid = 1'b0;
        total++; if (hs1 < 0 || hs2 < 0 || hs2 - hs1 != 4) begin
            bad++; $display("FAIL b2b_spacing: got hs1=%0d hs2=%0d want spacing 4", hs1, hs2);
        end
        total++; if (zero_cnt != 3) begin bad++; $display("FAIL b2b_busy_ready: got %0d low cycles want 3", zero_cnt); end
        total++; if (rf[3] !== 8'h32 || rf[6] !== 8'h32) begin
            bad++; $display("FAIL b2b_result: got r3=%h r6=%h want 32 32", rf[3], rf[6]);
        end
    endtask

    task automatic test_alias();
        int lat;
        preload(4'd1, 8'h40); preload(4'd11, 8'h5A);
        issue(3'b000, 4'd1, 4'd1, 4'd1);
        cmd_valid = 1'b1; cmd_op = 3'b010; cmd_dst = 4'd11; cmd_src1 = 4'd2; cmd_src2 = 4'd2;
        finish_cmd(lat);
        cmd_valid = 1'b0;
        total++; if (lat != 3) begin bad++; $display("FAIL alias_latency: got %0d want 3", lat); end
        total++; if (rf[1] !== 8'h80 || flag_c !== 1'b0) begin
            bad++; $display("FAIL alias_result: got %h c=%0b want 80 0", rf[1], flag_c);
        end
        repeat (6) @(posedge clk);
        #1;
        total++; if (rf[11] !== 8'h5A) begin bad++; $display("FAIL alias_busy_ignored: got r11=%h want 5a", rf[11]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub_shift();
        test_mid_reset();
        test_back_to_back();
        test_alias();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
